// File: rtl/cpu_regs_pkg.sv
// Shared constants and types for the CPU register bank: widths, register
// indices and reset values.
package cpu_regs_pkg;

    localparam int DATA_W_DEF = 16;

    typedef logic [2:0] reg_idx_t;

    localparam reg_idx_t REG_SP = 3'd6;
    localparam reg_idx_t REG_PC = 3'd7;

    localparam logic [15:0] SP_INIT_DEF = 16'h00FF;
    localparam logic [15:0] PC_INIT_DEF = 16'h0000;

    // One-hot decode of a register index, used for write-port selection.
    function automatic logic [7:0] idx_onehot(input reg_idx_t idx);
        logic [7:0] oh;
        oh = 8'h01 << idx;
        return oh;
    endfunction

endpackage

// File: rtl/gpr_cell.sv
// Single register of the bank: asynchronous active-low reset to a
// parameterised value, loads i_d when i_ld is high.
module gpr_cell #(
    parameter int          DATA_W  = 16,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ld,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    // Storage element with load enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RST_VAL;
        end else if (i_ld) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/gpr_bank8x16.sv
// Eight-entry register bank with one write port, R7 (PC) auto-increment,
// R6 (SP) push/pop and sticky stack-error flags. Optional macro
// GPR_REG0_ZERO_EN hardwires R0 to zero.
module gpr_bank8x16
    import cpu_regs_pkg::*;
#(
    parameter int                DATA_W  = DATA_W_DEF,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_INIT_DEF),
    parameter logic [DATA_W-1:0] PC_INIT = DATA_W'(PC_INIT_DEF)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              WR_EN,
    input  logic [2:0]        WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic              PC_INC,
    input  logic              SP_PUSH,
    input  logic              SP_POP,
    input  logic              CLR_ERR,
    output logic [DATA_W-1:0] R_OUT0,
    output logic [DATA_W-1:0] R_OUT1,
    output logic [DATA_W-1:0] R_OUT2,
    output logic [DATA_W-1:0] R_OUT3,
    output logic [DATA_W-1:0] R_OUT4,
    output logic [DATA_W-1:0] R_OUT5,
    output logic [DATA_W-1:0] R_OUT6,
    output logic [DATA_W-1:0] R_OUT7,
    output logic              SP_UNDER,
    output logic              SP_OVER
);

    localparam logic [DATA_W-1:0] ONE_C = DATA_W'(1);
    localparam logic [DATA_W-1:0] ZERO_C = DATA_W'(0);
    localparam logic [DATA_W-1:0] ALL1_C = ~ZERO_C;

    logic [7:0]        w_wr_sel;
    logic [7:0]        w_ld;
    logic [DATA_W-1:0] w_d [8];
    logic [DATA_W-1:0] w_q [8];
    logic              w_under_set;
    logic              w_over_set;
    logic              r_sp_under;
    logic              r_sp_over;

    assign w_wr_sel = WR_EN ? idx_onehot(reg_idx_t'(WR_ADDR)) : 8'h00;

    // Per-register load enables and next values; a write always beats
    // the PC increment or SP adjustment targeting the same register.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_ld[i] = w_wr_sel[i];
            w_d[i]  = WR_DATA;
        end
`ifdef GPR_REG0_ZERO_EN
        w_ld[0] = 1'b0;
`endif
        w_under_set = 1'b0;
        w_over_set  = 1'b0;

        if (w_wr_sel[REG_PC]) begin
            w_d[REG_PC] = WR_DATA;
        end else if (PC_INC) begin
            w_ld[REG_PC] = 1'b1;
            w_d[REG_PC]  = w_q[REG_PC] + ONE_C;
        end else begin
            w_d[REG_PC] = w_q[REG_PC];
        end

        if (w_wr_sel[REG_SP]) begin
            w_d[REG_SP] = WR_DATA;
        end else if (SP_PUSH && !SP_POP) begin
            w_ld[REG_SP] = 1'b1;
            w_d[REG_SP]  = w_q[REG_SP] - ONE_C;
            w_under_set  = (w_q[REG_SP] == ZERO_C);
        end else if (SP_POP && !SP_PUSH) begin
            w_ld[REG_SP] = 1'b1;
            w_d[REG_SP]  = w_q[REG_SP] + ONE_C;
            w_over_set   = (w_q[REG_SP] == ALL1_C);
        end else begin
            w_d[REG_SP] = w_q[REG_SP];
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_cell
        localparam logic [DATA_W-1:0] RV = (g == 6) ? SP_INIT :
                                           (g == 7) ? PC_INIT : ZERO_C;
        gpr_cell #(
            .DATA_W  (DATA_W),
            .RST_VAL (RV)
        ) u_cell (
            .i_clk   (CLK),
            .i_rst_n (RST_N),
            .i_ld    (w_ld[g]),
            .i_d     (w_d[g]),
            .o_q     (w_q[g])
        );
    end

    // Sticky error flags; a new error in the same cycle as CLR_ERR wins.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sp_under <= 1'b0;
            r_sp_over  <= 1'b0;
        end else begin
            if (w_under_set) begin
                r_sp_under <= 1'b1;
            end else if (CLR_ERR) begin
                r_sp_under <= 1'b0;
            end else begin
                r_sp_under <= r_sp_under;
            end
            if (w_over_set) begin
                r_sp_over <= 1'b1;
            end else if (CLR_ERR) begin
                r_sp_over <= 1'b0;
            end else begin
                r_sp_over <= r_sp_over;
            end
        end
    end

    assign R_OUT0   = w_q[0];
    assign R_OUT1   = w_q[1];
    assign R_OUT2   = w_q[2];
    assign R_OUT3   = w_q[3];
    assign R_OUT4   = w_q[4];
    assign R_OUT5   = w_q[5];
    assign R_OUT6   = w_q[6];
    assign R_OUT7   = w_q[7];
    assign SP_UNDER = r_sp_under;
    assign SP_OVER  = r_sp_over;

endmodule

// File: tb/tb_gpr_bank8x16.sv
// Directed, table-driven bench for gpr_bank8x16 with hand-written
// sequences for sticky flags, concurrent updates and mid-run reset.
module tb_gpr_bank8x16;

    logic        CLK;
    logic        RST_N;
    logic        WR_EN;
    logic [2:0]  WR_ADDR;
    logic [15:0] WR_DATA;
    logic        PC_INC;
    logic        SP_PUSH;
    logic        SP_POP;
    logic        CLR_ERR;
    logic [15:0] r_out [8];
    logic        SP_UNDER;
    logic        SP_OVER;

    int checks;
    int failures;

    gpr_bank8x16 dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .WR_EN    (WR_EN),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .PC_INC   (PC_INC),
        .SP_PUSH  (SP_PUSH),
        .SP_POP   (SP_POP),
        .CLR_ERR  (CLR_ERR),
        .R_OUT0   (r_out[0]),
        .R_OUT1   (r_out[1]),
        .R_OUT2   (r_out[2]),
        .R_OUT3   (r_out[3]),
        .R_OUT4   (r_out[4]),
        .R_OUT5   (r_out[5]),
        .R_OUT6   (r_out[6]),
        .R_OUT7   (r_out[7]),
        .SP_UNDER (SP_UNDER),
        .SP_OVER  (SP_OVER)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr_en;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        pc_inc;
        logic        push;
        logic        pop;
        logic        clr;
        logic [2:0]  idx;
        logic [15:0] exp;
        logic        eu;
        logic        eo;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic we, input logic [2:0] a, input logic [15:0] d,
                        input logic pi, input logic pu, input logic po, input logic cl);
        @(negedge CLK);
        WR_EN = we; WR_ADDR = a; WR_DATA = d;
        PC_INC = pi; SP_PUSH = pu; SP_POP = po; CLR_ERR = cl;
        @(posedge CLK);
        #1;
        WR_EN = 1'b0; PC_INC = 1'b0; SP_PUSH = 1'b0; SP_POP = 1'b0; CLR_ERR = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        for (int i = 0; i < 6; i++) chk($sformatf("%s_r%0d", tag, i), r_out[i], 16'h0000);
        chk({tag, "_r6"}, r_out[6], 16'h00FF);
        chk({tag, "_r7"}, r_out[7], 16'h0000);
        chk({tag, "_under"}, {15'd0, SP_UNDER}, 16'h0000);
        chk({tag, "_over"}, {15'd0, SP_OVER}, 16'h0000);
    endtask

    initial begin
        checks = 0; failures = 0;
        WR_EN = 1'b0; WR_ADDR = 3'd0; WR_DATA = 16'h0000;
        PC_INC = 1'b0; SP_PUSH = 1'b0; SP_POP = 1'b0; CLR_ERR = 1'b0;

        //          we    addr  data       pc    push  pop   clr   idx   exp        eu    eo
        vt[0]  = '{1'b1, 3'd3, 16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'hA5A5, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 16'h0000, 1'b0, 1'b0};
`ifdef GPR_REG0_ZERO_EN
        vt[2]  = '{1'b1, 3'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
`else
        vt[2]  = '{1'b1, 3'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h1234, 1'b0, 1'b0};
`endif
        vt[3]  = '{1'b1, 3'd7, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 16'hFFFE, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 16'hFFFF, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 16'h0000, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 3'd7, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 16'h0100, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 3'd6, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 16'h0000, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 16'h0000, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 16'hFFFF, 1'b1, 1'b0};
        vt[10] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 16'h0000, 1'b1, 1'b1};
        vt[11] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 16'h0000, 1'b0, 1'b0};
        vt[12] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 16'hFFFF, 1'b1, 1'b0};
        vt[13] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 16'hFFFF, 1'b0, 1'b0};
        vt[14] = '{1'b1, 3'd6, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 16'h0000, 1'b0, 1'b0};
        vt[15] = '{1'b1, 3'd6, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 16'h00FF, 1'b0, 1'b0};
        vt[16] = '{1'b1, 3'd7, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 16'h0010, 1'b0, 1'b0};
        vt[17] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 16'h0100, 1'b0, 1'b0};

        RST_N = 1'b0;
        #12;
        chk_reset_state("init");
        @(negedge CLK);
        RST_N = 1'b1;

        for (int v = 0; v < 18; v++) begin
            step(vt[v].wr_en, vt[v].addr, vt[v].data, vt[v].pc_inc, vt[v].push, vt[v].pop, vt[v].clr);
            chk($sformatf("vec%0d_r%0d", v, vt[v].idx), r_out[vt[v].idx], vt[v].exp);
            chk($sformatf("vec%0d_under", v), {15'd0, SP_UNDER}, {15'd0, vt[v].eu});
            chk($sformatf("vec%0d_over", v), {15'd0, SP_OVER}, {15'd0, vt[v].eo});
        end

        // Concurrent updates: R6=0x00FF, R7=0x0010 set up directly
        step(1'b1, 3'd6, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd2, 16'h0042, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("conc_r2", r_out[2], 16'h0042);
        chk("conc_r6", r_out[6], 16'h00FE);
        chk("conc_r7", r_out[7], 16'h0011);
        chk("conc_r3_held", r_out[3], 16'hA5A5);

        // Sticky underflow through idle cycles, then clear
        step(1'b1, 3'd6, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("uf_r6", r_out[6], 16'hFFFF);
        chk("uf_flag", {15'd0, SP_UNDER}, 16'h0001);
        for (int k = 0; k < 5; k++) step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("uf_sticky", {15'd0, SP_UNDER}, 16'h0001);
        chk("uf_r6_held", r_out[6], 16'hFFFF);
        chk("uf_pc_held", r_out[7], 16'h0011);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("uf_clr", {15'd0, SP_UNDER}, 16'h0000);

        // Asynchronous reset mid-run, with strobes active
        @(negedge CLK);
        WR_EN = 1'b1; WR_ADDR = 3'd4; WR_DATA = 16'hBEEF; PC_INC = 1'b1; SP_POP = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        chk_reset_state("async");
        @(posedge CLK);
        #1;
        chk_reset_state("held");
        @(negedge CLK);
        WR_EN = 1'b0; PC_INC = 1'b0; SP_POP = 1'b0;
        RST_N = 1'b1;
        step(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_pc", r_out[7], 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
